// File: rtl/seg_scan_readback.sv
// rtl/seg_scan_readback.sv - encodes scanned 7-segment digit/segment lines back into a 32-bit value
// Captures each digit after SETTLE stable cycles and reports frames and unknown patterns.
module seg_scan_readback #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  seg,
    output logic [31:0] value,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        bad_pattern
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    typedef enum logic {
        WAIT = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    an_r, seg_r;
    logic [7:0]    seen, seen_next;
    logic          changed;
    logic          capture;

    logic [7:0]    sel;
    logic          one_digit;
    logic [2:0]    idx;
    logic          hit;
    logic [3:0]    nib;
    logic          blank;
    logic          cap_ok;

    // seg[7] (dp) is deliberately left out of the lookup
    function automatic logic [4:0] encode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h7E:   r = 5'h10;
            7'h30:   r = 5'h11;
            7'h6D:   r = 5'h12;
            7'h79:   r = 5'h13;
            7'h33:   r = 5'h14;
            7'h5B:   r = 5'h15;
            7'h5F:   r = 5'h16;
            7'h70:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h7B:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h1F:   r = 5'h1B;
            7'h4E:   r = 5'h1C;
            7'h3D:   r = 5'h1D;
            7'h4F:   r = 5'h1E;
            7'h47:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Any input change restarts the stability count, whatever the state
    always_comb begin
        changed    = ({an, seg} != {an_r, seg_r});
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        if (changed) begin
            state_next = WAIT;
            cnt_next   = '0;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == LAST) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                HELD: begin
                    state_next = HELD;
                end
                default: begin
                    state_next = WAIT;
                end
            endcase
        end
    end

    always_comb begin
        sel       = ~an_r;
        one_digit = (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
        idx       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                idx = 3'(i);
            end
        end
        {hit, nib} = encode(seg_r[6:0]);
        blank      = (seg_r[6:0] == 7'h00);
        cap_ok     = capture && one_digit;
    end

    // A full mask is cleared on the pulse edge; a capture on that edge survives
    always_comb begin
        seen_next = (seen == 8'hFF) ? 8'h00 : seen;
        if (cap_ok) begin
            seen_next[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r        <= 8'hFF;
            seg_r       <= 8'h00;
            value       <= 32'h0;
            digit_valid <= 8'h00;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            seen        <= 8'h00;
        end else begin
            an_r        <= an;
            seg_r       <= seg;
            seen        <= seen_next;
            frame_done  <= (seen == 8'hFF);
            bad_pattern <= cap_ok && !hit && !blank;
            if (cap_ok) begin
                digit_valid[idx] <= hit;
                if (hit) begin
                    value[{idx, 2'b00} +: 4] <= nib;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_readback.sv
// tb/tb_seg_scan_readback.sv - self-checking bench for seg_scan_readback
// Run-length reference model checked every cycle, plus directed literal checks.
module tb_seg_scan_readback;

    localparam int SETTLE = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        bad_pattern;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    int bp_cnt   = 0;

    seg_scan_readback #(.SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic [15:0] m_last;
    int          m_run;
    logic [31:0] m_value;
    logic [7:0]  m_valid;
    logic [7:0]  m_seen;
    logic        m_pend;
    logic        m_fd;
    logic        m_bp;

    // A stable run of SETTLE edges after the first sample yields one capture
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last  = 16'hFF00;
            m_run   = 0;
            m_value = 0;
            m_valid = 0;
            m_seen  = 0;
            m_pend  = 0;
            m_fd    = 0;
            m_bp    = 0;
        end else begin
            m_bp = 1'b0;
            m_fd = m_pend;
            if (m_pend) m_seen = 8'h00;
            if ({an, seg} != m_last) begin
                m_last = {an, seg};
                m_run  = 0;
            end else begin
                if (m_run < 1000) m_run = m_run + 1;
                if (m_run == SETTLE && $countones(~m_last[15:8]) == 1) begin
                    int d;
                    int code;
                    d = 0;
                    code = -1;
                    for (int i = 0; i < 8; i++) if (!m_last[8 + i]) d = i;
                    for (int k = 0; k < 16; k++) if (codes[k] == m_last[6:0]) code = k;
                    m_seen[d] = 1'b1;
                    if (code >= 0) begin
                        m_valid[d] = 1'b1;
                        m_value[4*d +: 4] = 4'(code);
                    end else begin
                        m_valid[d] = 1'b0;
                        m_bp = (m_last[6:0] != 7'h00);
                    end
                end
            end
            m_pend = (m_seen == 8'hFF);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_value", value, m_value);
            chk("cyc_digit_valid", {24'h0, digit_valid}, {24'h0, m_valid});
            chk("cyc_frame_done", {31'h0, frame_done}, {31'h0, m_fd});
            chk("cyc_bad_pattern", {31'h0, bad_pattern}, {31'h0, m_bp});
            if (frame_done === 1'b1) fd_cnt++;
            if (bad_pattern === 1'b1) bp_cnt++;
        end
    end

    task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        an  = 8'hFF;
        seg = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_value", value, 32'h0);
        chk("rst_valid", {24'h0, digit_valid}, 32'h0);
        chk("rst_fd", {31'h0, frame_done}, 32'h0);
        chk("rst_bp", {31'h0, bad_pattern}, 32'h0);
        rst = 1'b0;

        hold(8'hFE, 8'h79, 4);
        chk("pre_settle_valid", {24'h0, digit_valid}, 32'h0);
        hold(8'hFE, 8'h79, 1);
        chk("first_value", value, 32'h3);
        chk("first_valid", {24'h0, digit_valid}, 32'h01);
        chk("first_no_pulse", fd_cnt + bp_cnt, 0);

        for (int d = 0; d < 8; d++) hold(~(8'd1 << d), {1'b0, codes[d]}, 6);
        chk("scan_value", value, 32'h76543210);
        chk("scan_valid", {24'h0, digit_valid}, 32'hFF);
        chk("scan_frames", fd_cnt, 1);

        hold(8'hFB, 8'h7F, 3);
        hold(8'hFF, 8'h00, 2);
        chk("short_dwell_value", value, 32'h76543210);
        chk("short_dwell_valid", {24'h0, digit_valid}, 32'hFF);

        hold(8'hFD, 8'h12, 6);
        chk("bad_count", bp_cnt, 1);
        chk("bad_valid", {24'h0, digit_valid}, 32'hFD);
        chk("bad_value", value, 32'h76543210);
        hold(8'hFD, 8'h77, 6);
        chk("fix_value", value, 32'h765432A0);
        chk("fix_valid", {24'h0, digit_valid}, 32'hFF);

        hold(8'hFC, 8'hB3, 10);
        hold(8'hFF, 8'h33, 10);
        chk("multi_blank_value", value, 32'h765432A0);
        chk("multi_blank_pulses", fd_cnt * 16 + bp_cnt, 17);
        hold(8'hF7, 8'h80, 6);
        chk("blank_digit_valid", {24'h0, digit_valid}, 32'hF7);
        chk("blank_digit_bp", bp_cnt, 1);
        chk("blank_digit_value", value, 32'h765432A0);

        hold(8'hDF, 8'h4F, 3);
        hold(8'hDF, 8'h00, 1);
        hold(8'hDF, 8'h4F, 4);
        chk("glitch_no_capture", value, 32'h765432A0);
        hold(8'hDF, 8'h4F, 1);
        chk("glitch_capture", value, 32'h76E432A0);

        hold(8'h7F, 8'h70, 6);
        hold(8'hBF, 8'h5B, 3);
        rst = 1'b1;
        #1;
        chk("midrst_value", value, 32'h0);
        chk("midrst_valid", {24'h0, digit_valid}, 32'h0);
        chk("midrst_pulses", {30'h0, frame_done, bad_pattern}, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        hold(8'hBF, 8'h5B, 4);
        chk("post_rst_wait", {24'h0, digit_valid}, 32'h0);
        hold(8'hBF, 8'h5B, 1);
        chk("post_rst_value", value, 32'h05000000);
        chk("post_rst_valid", {24'h0, digit_valid}, 32'h40);
        for (int d = 0; d < 6; d++) hold(~(8'd1 << d), 8'h30, 6);
        chk("post_rst_no_frame", fd_cnt, 1);
        hold(8'h7F, 8'h70, 6);
        chk("post_rst_frame", fd_cnt, 2);
        chk("post_rst_final", value, 32'h75111111);
        chk("post_rst_fvalid", {24'h0, digit_valid}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
